regfile_sequencer: RTL and testbench

Control sequencer for the 9-word x 24-bit pixel SRAM and its muxes. It drives the one-hot wordline select, the rotating row pointer, the bit-serial pixel mux select and the write enable. It first steps the datapath through a kernel-read pass, then streams image pixels bit-serially, writing each new pixel into the oldest row. It sits between the pad-side pixel source (valid/ready) and the SRAM block, replacing the free-running counters.

---
 rtl/regfile_sequencer_pkg.sv | 12 +
 rtl/regfile_sequencer_onehot_ring.sv | 28 ++
 rtl/regfile_sequencer.sv | 144 ++++++++++++++
 tb/tb_regfile_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sequencer_pkg.sv
// rtl/regfile_sequencer_pkg.sv - shared state type and constants for the pixel SRAM sequencer
package regfile_pkg;

  typedef enum logic [1:0] {IDLE, KERNEL, PIXEL, DONE} seq_state_t;

  localparam int DEF_NUM_WORDS = 9;
  localparam int DEF_PIX_BITS  = 8;

  // Oldest-row pointer visits these in order, index 0 is the reset/restart value
  localparam logic [2:0][2:0] PTR_SEQ = {3'b100, 3'b010, 3'b001};

endpackage

// File: rtl/regfile_sequencer_onehot_ring.sv
// rtl/regfile_sequencer_onehot_ring.sv - one-hot rotating register with clear, load and advance
module onehot_ring #(
  parameter int               WIDTH      = 8,
  parameter bit               SHIFT_LEFT = 1'b1,
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  // Rotation keeps the value one-hot; clear wins over load, load over advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= RESET_VAL;
    else if (clear)
      q <= '0;
    else if (load)
      q <= SEED;
    else if (advance)
      q <= SHIFT_LEFT ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
  end

endmodule

// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - kernel-read pass then bit-serial pixel streaming into the oldest SRAM row
module regfile_sequencer
  import regfile_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int PIX_BITS  = DEF_PIX_BITS,
  parameter int IMG_ROWS  = 16,
  parameter int ROW_CNT_W = 8
) (
  input  logic                 phi1,
  input  logic                 reset_s1,
  input  logic                 start_s1,
  input  logic                 pix_valid_s1,
  output logic                 pix_ready_s1,
  output logic [NUM_WORDS-1:0] wrapout_s1,
  output logic [2:0]           Mem_Pointer_s1,
  output logic [PIX_BITS-1:0]  Pix_Mux_s1,
  output logic                 Write_Mem_s1,
  output logic                 kernel_phase_s1,
  output logic                 conv_valid_s1,
  output logic                 busy_s1,
  output logic                 done_s1,
  output logic [ROW_CNT_W-1:0] row_cnt_s1
);

  localparam int WW = $clog2(NUM_WORDS);
  localparam int BW = $clog2(PIX_BITS);
  localparam logic [WW-1:0]        LAST_WORD    = WW'(NUM_WORDS - 1);
  localparam logic [BW-1:0]        LAST_BIT     = BW'(PIX_BITS - 1);
  localparam logic [BW-1:0]        PRE_LAST_BIT = BW'(PIX_BITS - 2);
  localparam logic [ROW_CNT_W-1:0] LAST_ROW     = ROW_CNT_W'(IMG_ROWS - 1);

  seq_state_t    state;
  logic [WW-1:0] word;
  logic [BW-1:0] bit_idx;

  logic last_word, last_bit, last_row, commit, frame_end;
  logic wl_load, wl_adv, wl_clr, pm_load, pm_adv, pm_clr, rp_load, rp_adv;

  assign last_word = (word == LAST_WORD);
  assign last_bit  = (bit_idx == LAST_BIT);
  assign last_row  = (row_cnt_s1 == LAST_ROW);
  // commit marks the write cycle: the pixel is taken and the next word begins
  assign commit    = (state == PIXEL) && last_bit && Write_Mem_s1;
  assign frame_end = commit && last_word && last_row;

  assign wl_load = ((state == IDLE) && start_s1) || ((state == KERNEL) && last_word) ||
                   (commit && last_word && !last_row);
  assign wl_adv  = ((state == KERNEL) && !last_word) || (commit && !last_word);
  assign wl_clr  = frame_end;
  assign pm_load = (state == KERNEL) && last_word;
  assign pm_adv  = ((state == PIXEL) && !last_bit) || (commit && !frame_end);
  assign pm_clr  = frame_end;
  assign rp_load = (state == DONE);
  assign rp_adv  = commit && last_word && !last_row;

  onehot_ring #(.WIDTH(NUM_WORDS), .SHIFT_LEFT(1'b0),
                .SEED({1'b1, {(NUM_WORDS-1){1'b0}}}), .RESET_VAL('0)) u_wordline (
    .clk(phi1), .rst(reset_s1), .load(wl_load), .advance(wl_adv), .clear(wl_clr), .q(wrapout_s1)
  );

  onehot_ring #(.WIDTH(PIX_BITS), .SHIFT_LEFT(1'b1),
                .SEED(PIX_BITS'(1)), .RESET_VAL('0)) u_pix_mux (
    .clk(phi1), .rst(reset_s1), .load(pm_load), .advance(pm_adv), .clear(pm_clr), .q(Pix_Mux_s1)
  );

  onehot_ring #(.WIDTH(3), .SHIFT_LEFT(1'b1),
                .SEED(PTR_SEQ[0]), .RESET_VAL(PTR_SEQ[0])) u_row_ptr (
    .clk(phi1), .rst(reset_s1), .load(rp_load), .advance(rp_adv), .clear(1'b0), .q(Mem_Pointer_s1)
  );

  always_ff @(posedge phi1 or posedge reset_s1) begin
    if (reset_s1) begin
      state           <= IDLE;
      word            <= '0;
      bit_idx         <= '0;
      pix_ready_s1    <= 1'b0;
      Write_Mem_s1    <= 1'b0;
      kernel_phase_s1 <= 1'b0;
      conv_valid_s1   <= 1'b0;
      busy_s1         <= 1'b0;
      done_s1         <= 1'b0;
      row_cnt_s1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_s1) begin
            state           <= KERNEL;
            word            <= '0;
            kernel_phase_s1 <= 1'b1;
            busy_s1         <= 1'b1;
          end
        end
        KERNEL: begin
          if (last_word) begin
            state           <= PIXEL;
            word            <= '0;
            bit_idx         <= '0;
            kernel_phase_s1 <= 1'b0;
          end else begin
            word <= word + 1'b1;
          end
        end
        PIXEL: begin
          // Valid is sampled entering the last bit so the write strobe can be a flop
          if (!last_bit) begin
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == PRE_LAST_BIT) begin
              pix_ready_s1 <= 1'b1;
              Write_Mem_s1 <= pix_valid_s1;
            end
          end else if (!Write_Mem_s1) begin
            Write_Mem_s1 <= pix_valid_s1;
          end else begin
            Write_Mem_s1 <= 1'b0;
            pix_ready_s1 <= 1'b0;
            bit_idx      <= '0;
            if (!last_word) begin
              word <= word + 1'b1;
            end else begin
              word       <= '0;
              row_cnt_s1 <= row_cnt_s1 + 1'b1;
              if (last_row) begin
                state   <= DONE;
                done_s1 <= 1'b1;
              end else begin
                conv_valid_s1 <= (row_cnt_s1 >= ROW_CNT_W'(1));
              end
            end
          end
        end
        DONE: begin
          state         <= IDLE;
          done_s1       <= 1'b0;
          busy_s1       <= 1'b0;
          row_cnt_s1    <= '0;
          conv_valid_s1 <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// tb/tb_regfile_sequencer.sv - scoreboard bench for regfile_sequencer (3-row and 16-row instances)
module tb_regfile_sequencer;

  logic phi1 = 1'b0;
  logic rst, start, valid;

  logic       rdy3, wr3, kph3, conv3, busy3, done3;
  logic [8:0] wrap3;
  logic [2:0] ptr3;
  logic [7:0] pix3, row3;
  logic       rdy16, wr16, kph16, conv16, busy16, done16;
  logic [8:0] wrap16;
  logic [2:0] ptr16;
  logic [7:0] pix16, row16;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  bit saw_done16;

  typedef struct {
    int ph;
    int word;
    int bitp;
    int row;
    bit wr;
    bit rdy;
    bit conv;
  } mdl_t;

  mdl_t m3, m16;
  logic [63:0] sb3[$];
  logic [63:0] sb16[$];

  localparam logic [63:0] RST_VEC = {30'b0, 1'b0, 9'b0, 3'b001, 8'b0, 5'b0, 8'b0};

  always #5 phi1 = ~phi1;

  regfile_sequencer #(.IMG_ROWS(3)) dut3 (
    .phi1(phi1), .reset_s1(rst), .start_s1(start), .pix_valid_s1(valid),
    .pix_ready_s1(rdy3), .wrapout_s1(wrap3), .Mem_Pointer_s1(ptr3), .Pix_Mux_s1(pix3),
    .Write_Mem_s1(wr3), .kernel_phase_s1(kph3), .conv_valid_s1(conv3), .busy_s1(busy3),
    .done_s1(done3), .row_cnt_s1(row3)
  );

  regfile_sequencer #(.IMG_ROWS(16)) dut16 (
    .phi1(phi1), .reset_s1(rst), .start_s1(start), .pix_valid_s1(valid),
    .pix_ready_s1(rdy16), .wrapout_s1(wrap16), .Mem_Pointer_s1(ptr16), .Pix_Mux_s1(pix16),
    .Write_Mem_s1(wr16), .kernel_phase_s1(kph16), .conv_valid_s1(conv16), .busy_s1(busy16),
    .done_s1(done16), .row_cnt_s1(row16)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: phase 0 idle, 1 kernel, 2 pixel, 3 done
  function automatic mdl_t mdl_next(mdl_t m, logic r, logic st, logic vl, int rows);
    mdl_t x;
    x = m;
    if (r) begin
      x = '{default: 0};
      return x;
    end
    case (m.ph)
      0: if (st) begin x.ph = 1; x.word = 0; end
      1: if (m.word == 8) begin x.ph = 2; x.word = 0; x.bitp = 0; end
         else x.word = m.word + 1;
      2: begin
        if (m.bitp < 7) begin
          x.bitp = m.bitp + 1;
          if (x.bitp == 7) begin x.rdy = 1; x.wr = vl; end
        end else if (!m.wr) begin
          x.wr = vl;
        end else begin
          x.wr = 0; x.rdy = 0; x.bitp = 0;
          if (m.word < 8) x.word = m.word + 1;
          else begin
            x.word = 0;
            x.row  = m.row + 1;
            if (x.row == rows) x.ph = 3;
            else if (x.row >= 2) x.conv = 1;
          end
        end
      end
      default: begin x.ph = 0; x.row = 0; x.conv = 0; end
    endcase
    return x;
  endfunction

  function automatic logic [63:0] mdl_vec(mdl_t m);
    logic [8:0] w;
    logic [7:0] p;
    logic [2:0] pt;
    int pr;
    w  = (m.ph == 1 || m.ph == 2) ? 9'(1 << (8 - m.word)) : 9'b0;
    p  = (m.ph == 2) ? 8'(1 << m.bitp) : 8'b0;
    pr = (m.ph == 3) ? m.row - 1 : m.row;
    pt = 3'(1 << (pr % 3));
    return {30'b0, m.rdy, w, pt, p, m.wr, m.ph == 1, m.conv, m.ph != 0, m.ph == 3, 8'(m.row)};
  endfunction

  function automatic logic [63:0] vec3();
    return {30'b0, rdy3, wrap3, ptr3, pix3, wr3, kph3, conv3, busy3, done3, row3};
  endfunction

  function automatic logic [63:0] vec16();
    return {30'b0, rdy16, wrap16, ptr16, pix16, wr16, kph16, conv16, busy16, done16, row16};
  endfunction

  task automatic tick();
    @(posedge phi1);
    m3  = mdl_next(m3, rst, start, valid, 3);
    m16 = mdl_next(m16, rst, start, valid, 16);
    sb3.push_back(mdl_vec(m3));
    sb16.push_back(mdl_vec(m16));
    @(negedge phi1);
    check_val("sb3", vec3(), sb3.pop_front());
    check_val("sb16", vec16(), sb16.pop_front());
    check_val("onehot3", {61'b0, $onehot0(wrap3), $onehot0(pix3), $onehot(ptr3)}, 64'd7);
    check_val("onehot16", {61'b0, $onehot0(wrap16), $onehot0(pix16), $onehot(ptr16)}, 64'd7);
    if (done16) saw_done16 = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0;
    m3 = '{default: 0};
    m16 = '{default: 0};
    saw_done16 = 1'b0;
    repeat (2) tick();
    check_val("rst_vec", vec3(), RST_VEC);
    rst = 1'b0;
    tick();

    // Frame A: valid always high, 3-row frame timing
    valid = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      check_val("kern_wrap", wrap3, 64'(9'h100 >> i));
      check_val("kern_flags", {kph3, wr3, pix3}, {1'b1, 1'b0, 8'h00});
      tick();
      n++;
    end
    check_val("pix_first", {kph3, pix3, wrap3}, {1'b0, 8'h01, 9'h100});
    while (!done3 && n < 400) begin
      start = (n == 60);
      tick();
      n++;
    end
    start = 1'b0;
    check_val("done_latency", 64'(n), 64'd225);
    check_val("done_state", {conv3, row3, ptr3, wrap3, pix3}, {1'b1, 8'd3, 3'b100, 9'h0, 8'h0});

    // start coinciding with done is ignored, one cycle later it starts a frame
    start = 1'b1;
    tick();
    check_val("start_at_done", {busy3, kph3, ptr3, row3}, {2'b00, 3'b001, 8'd0});
    tick();
    start = 1'b0;
    check_val("start_idle", {busy3, kph3, wrap3}, {2'b11, 9'h100});

    // Frame B: stall at bit 7 of word 4
    n = 0;
    while (n < 47) begin tick(); n++; end
    check_val("pre_stall", {wrap3, pix3}, {9'h010, 8'h40});
    valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_val("stall", {wrap3, pix3, wr3, rdy3, ptr3}, {9'h010, 8'h80, 1'b0, 1'b1, 3'b001});
    end
    valid = 1'b1;
    tick();
    check_val("stall_write", {wrap3, pix3, wr3, rdy3}, {9'h010, 8'h80, 1'b1, 1'b1});
    tick();
    check_val("after_write", {wrap3, pix3, wr3, rdy3}, {9'h008, 8'h01, 1'b0, 1'b0});

    // Asynchronous reset mid-word aborts both frames
    repeat (30) tick();
    #2 rst = 1'b1;
    #1;
    check_val("async_rst3", vec3(), RST_VEC);
    check_val("async_rst16", vec16(), RST_VEC);
    m3 = '{default: 0};
    m16 = '{default: 0};
    #1 rst = 1'b0;
    repeat (4) tick();
    check_val("no_done_after_rst", {done3, done16, busy3, busy16}, 4'b0000);

    // Frame C: randomised valid, full 16-row frame
    saw_done16 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (n < 4000 && !(saw_done16 && m16.ph == 0)) begin
      valid = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check_val("frame16_done", {63'b0, saw_done16}, 64'd1);
    check_val("frame16_idle", {busy16, row16, ptr16}, {1'b0, 8'd0, 3'b001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
